// File: rtl/uart_host_bridge.sv
// uart_host_bridge: Wishbone master that configures a 16550-style UART, then polls LSR to move bytes
// between one-entry host TX/RX buffers and the UART THR/RBR.
module uart_host_bridge #(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VAL     = 8'h03,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    output logic [3:0] wbm_sel_o,
    input  logic       wbm_ack_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       init_done_o,
    output logic       err_o
);
    typedef enum logic [3:0] {
        INIT_LCR_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR, INIT_IER,
        POLL_LSR, DECIDE, READ_RBR, WRITE_THR
    } state_t;

    state_t     state_q, ack_next_d;
    logic       cyc_q, we_q, tx_full_q, rx_valid_q, init_done_q, err_q;
    logic [2:0] adr_q, adr_d;
    logic [7:0] dat_q, dat_d, cnt_q, tx_buf_q, rx_data_q, lsr_q;
    logic       we_d;

    // Access attributes of the current state and where its ack leads
    always_comb begin
        adr_d      = 3'd0;
        dat_d      = 8'h00;
        we_d       = 1'b1;
        ack_next_d = POLL_LSR;
        case (state_q)
            INIT_LCR_DLAB: begin adr_d = 3'd3; dat_d = 8'h80 | LCR_VAL; ack_next_d = INIT_DLL; end
            INIT_DLL:      begin adr_d = 3'd0; dat_d = DIVISOR[7:0];    ack_next_d = INIT_DLM; end
            INIT_DLM:      begin adr_d = 3'd1; dat_d = DIVISOR[15:8];   ack_next_d = INIT_LCR; end
            INIT_LCR:      begin adr_d = 3'd3; dat_d = LCR_VAL;         ack_next_d = INIT_FCR; end
            INIT_FCR:      begin adr_d = 3'd2; dat_d = 8'h07;           ack_next_d = INIT_IER; end
            INIT_IER:      begin adr_d = 3'd1; dat_d = 8'h00;           ack_next_d = POLL_LSR; end
            POLL_LSR:      begin adr_d = 3'd5; we_d = 1'b0;             ack_next_d = DECIDE;   end
            READ_RBR:      begin adr_d = 3'd0; we_d = 1'b0;                                    end
            WRITE_THR:     begin adr_d = 3'd0; dat_d = tx_buf_q;                               end
            default:       ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= INIT_LCR_DLAB;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 3'd0;
            dat_q       <= 8'h00;
            cnt_q       <= 8'h00;
            tx_full_q   <= 1'b0;
            tx_buf_q    <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            lsr_q       <= 8'h00;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (tx_valid_i && tx_ready_o) begin
                tx_full_q <= 1'b1;
                tx_buf_q  <= tx_data_i;
            end
            if (rx_valid_q && rx_ready_i)
                rx_valid_q <= 1'b0;
            if (state_q == DECIDE) begin
                state_q <= (lsr_q[0] && !rx_valid_q) ? READ_RBR :
                           (lsr_q[5] && tx_full_q)   ? WRITE_THR : POLL_LSR;
            end else if (!cyc_q) begin
                cyc_q <= 1'b1;
                adr_q <= adr_d;
                dat_q <= dat_d;
                we_q  <= we_d;
                cnt_q <= 8'h00;
            end else if (wbm_ack_i) begin
                cyc_q   <= 1'b0;
                state_q <= ack_next_d;
                if (state_q == POLL_LSR)
                    lsr_q <= wbm_dat_i;
                if (state_q == READ_RBR) begin
                    rx_data_q  <= wbm_dat_i;
                    rx_valid_q <= 1'b1;
                end
                if (state_q == WRITE_THR)
                    tx_full_q <= 1'b0;
                if (state_q == INIT_IER)
                    init_done_q <= 1'b1;
            end else if (int'(cnt_q) + 1 >= ACK_TIMEOUT) begin
                // Init steps retry in place; run-time accesses fall back to a fresh poll
                cyc_q   <= 1'b0;
                err_q   <= 1'b1;
                state_q <= init_done_q ? POLL_LSR : state_q;
            end else begin
                cnt_q <= cnt_q + {7'd0, cnt_q != 8'hff};
            end
        end
    end

    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_we_o    = we_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_sel_o   = 4'b0001;
    assign tx_ready_o  = init_done_q & ~tx_full_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge: directed checks of init sequence, TX/RX byte paths, ack timeout and mid-access reset.
module tb_uart_host_bridge;
    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] adr;
    logic [7:0] dat_o, dat_i, tx_data = 8'h00, rx_data, lsr = 8'h00, rbr = 8'h00;
    logic [3:0] sel;
    logic       we, stb, cyc, ack = 1'b0, tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
    logic       init_done, err, thr_ack_en = 1'b1;
    logic [11:0] log_q [0:1023];
    logic [7:0]  last_thr = 8'h00;
    int n_log = 0, thr_n = 0, rbr_n = 0, poll_n = 0, err_n = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    uart_host_bridge dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_we_o(we),
        .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_sel_o(sel), .wbm_ack_i(ack),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .init_done_o(init_done), .err_o(err)
    );

    // UART slave: LSR at adr 5, RBR elsewhere; THR writes may be refused
    assign dat_i = (adr == 3'd5) ? lsr : rbr;
    always @(posedge clk)
        ack <= rst ? 1'b0 : (cyc & stb & ~ack & (thr_ack_en | ~(we & adr == 3'd0)));

    always @(posedge clk) begin
        if (!rst && cyc && stb && ack) begin
            if (n_log < 1024) log_q[n_log] = {we, adr, we ? dat_o : dat_i};
            n_log++;
            if (we && adr == 3'd0 && init_done) begin thr_n++; last_thr = dat_o; end
            if (!we && adr == 3'd0) rbr_n++;
            if (!we && adr == 3'd5) poll_n++;
        end
        if (!rst && err) err_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        while (!tx_ready && k < 100) begin @(negedge clk); k++; end
        chk("tx_ready_wait", tx_ready, 1);
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    logic [11:0] init_exp [0:5] = '{12'hB83, 12'h81B, 12'h900, 12'hB03, 12'hA07, 12'h900};

    initial begin
        int base, k, t0, found, prev_done;
        logic [11:0] first0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_txrdy", tx_ready, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxd", rx_data, 0);
        chk("rst_done", init_done, 0);
        chk("rst_err", err, 0);
        chk("sel", sel, 4'b0001);

        // Init sequence with init_done rising exactly one cycle after the sixth ack
        @(negedge clk) rst = 1'b0;
        base = n_log; k = 0; prev_done = 1;
        while (n_log < base + 6 && k < 200) begin
            prev_done = init_done;
            @(negedge clk); k++;
        end
        chk("init_seen", n_log >= base + 6, 1);
        chk("done_before", prev_done, 0);
        chk("done_after", init_done, 1);
        for (int i = 0; i < 6; i++) chk($sformatf("init%0d", i), log_q[base + i], init_exp[i]);

        // TX path: A5 written once, tx_ready back the cycle after the ack
        lsr = 8'h20;
        t0 = thr_n;
        send(8'hA5);
        found = 0; k = 0;
        while (!found && k < 100) begin
            @(negedge clk); k++;
            found = int'(stb && ack && we && adr == 3'd0);
        end
        chk("thr_seen", found, 1);
        chk("thr_rdy_lo", tx_ready, 0);
        @(posedge clk); #1;
        chk("thr_rdy_hi", tx_ready, 1);
        repeat (40) @(negedge clk);
        chk("thr_once", thr_n - t0, 1);
        chk("thr_data", last_thr, 8'hA5);

        // RX priority over a pending TX byte
        lsr = 8'h00;
        repeat (10) @(negedge clk);
        send(8'h5A);
        repeat (10) @(negedge clk);
        base = n_log; t0 = thr_n;
        rbr = 8'h3C; lsr = 8'h21;
        k = 0;
        while (thr_n == t0 && k < 100) begin @(negedge clk); k++; end
        first0 = 12'hFFF;
        for (int i = base; i < n_log; i++)
            if (first0 == 12'hFFF && log_q[i][10:8] == 3'd0) first0 = log_q[i];
        chk("rbr_first", first0, 12'h03C);
        chk("rx_valid", rx_valid, 1);
        chk("rx_data", rx_data, 8'h3C);
        chk("thr2_data", last_thr, 8'h5A);

        // Back-pressure: no further RBR reads until the host takes the byte
        t0 = rbr_n; base = poll_n;
        rbr = 8'h77;
        repeat (60) @(negedge clk);
        chk("bp_noread", rbr_n - t0, 0);
        chk("bp_polling", poll_n > base, 1);
        chk("bp_hold", rx_data, 8'h3C);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("rx_taken", rx_valid, 0);
        rx_ready = 1'b0;
        k = 0;
        while (!rx_valid && k < 50) begin @(negedge clk); k++; end
        chk("rx_next", rx_data, 8'h77);
        lsr = 8'h00;
        repeat (10) @(negedge clk);

        // Ack timeout on WRITE_THR, then retry succeeds
        lsr = 8'h20; thr_ack_en = 1'b0;
        t0 = thr_n; base = err_n;
        send(8'hC3);
        k = 0;
        while (!(stb && we && adr == 3'd0) && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (stb && k < 400) begin k++; @(negedge clk); end
        chk("to_len", k, 255);
        chk("err_hi", err, 1);
        thr_ack_en = 1'b1;
        @(negedge clk);
        chk("err_lo", err, 0);
        k = 0;
        while (thr_n == t0 && k < 200) begin @(negedge clk); k++; end
        chk("retry_data", last_thr, 8'hC3);
        chk("retry_once", thr_n - t0, 1);
        chk("err_pulses", err_n - base, 1);

        // Reset in the middle of an access
        lsr = 8'h00;
        k = 0;
        while (!stb && k < 50) begin @(negedge clk); k++; end
        chk("mid_stb", stb, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_cyc", cyc, 0);
        chk("mid_stb0", stb, 0);
        chk("mid_rxv", rx_valid, 0);
        chk("mid_done", init_done, 0);
        @(negedge clk) rst = 1'b0;
        base = n_log; k = 0;
        while (!init_done && k < 200) begin @(negedge clk); k++; end
        chk("re_done", init_done, 1);
        chk("re_first", log_q[base], 12'hB83);
        chk("re_last", log_q[base + 5], 12'h900);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_host_bridge.md
UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 SHALL have parameter DIVISOR, default 16'd27, the 16-bit baud divisor written to DLL/DLM during init.
REQ-002 SHALL have parameter LCR_VAL, default 8'h03, the line control value (8N1) written after the divisor.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, the maximum wait cycles for wbm_ack_i per access.
REQ-004 SHALL use one clock and a synchronous, active-high reset: wb_clk_i (in, 1) clock; wb_rst_i (in, 1) reset.
REQ-005 SHALL have the following Wishbone master ports to the UART slave (8-bit data mode):
- wbm_adr_o out 3: register address.
- wbm_dat_o out 8: write data.
- wbm_dat_i in 8: read data.
- wbm_we_o out 1: write enable.
- wbm_stb_o out 1: strobe.
- wbm_cyc_o out 1: cycle.
- wbm_sel_o out 4: byte select, constant 4'b0001.
- wbm_ack_i in 1: acknowledge.
REQ-006 SHALL have the following host-side ports:
- tx_data_i in 8; tx_valid_i in 1; tx_ready_o out 1: transmit byte handshake.
- rx_data_o out 8; rx_valid_o out 1; rx_ready_i in 1: receive byte handshake.
- init_done_o out 1: UART configured.
- err_o out 1: one-cycle pulse on ack timeout.

Function
REQ-007 SHALL perform every bus access as a classic single cycle:
- cyc/stb/adr/we/dat held stable from assertion until the cycle wbm_ack_i=1 is sampled.
- cyc/stb deasserted the following cycle.
- At least one idle cycle between accesses.
REQ-008 SHALL run the init sequence after reset, in order, each a write:
- INIT_LCR_DLAB: adr 3 <= 8'h80|LCR_VAL.
- INIT_DLL: adr 0 <= DIVISOR[7:0].
- INIT_DLM: adr 1 <= DIVISOR[15:8].
- INIT_LCR: adr 3 <= LCR_VAL.
- INIT_FCR: adr 2 <= 8'h07.
- INIT_IER: adr 1 <= 8'h00.
REQ-009 SHALL set init_done_o=1 the cycle after the INIT_IER ack and hold it until reset.
REQ-010 SHALL, after init, loop POLL_LSR (read adr 5), then DECIDE.
REQ-011 In DECIDE, SHALL select the next state with RX priority:
- If LSR[0]=1 and the RX buffer is empty: READ_RBR (read adr 0).
- Else if LSR[5]=1 and the TX buffer is full: WRITE_THR (write adr 0 <= TX buffer).
- Else: POLL_LSR.
REQ-012 SHALL hold a one-entry TX buffer:
- tx_ready_o = init_done_o & TX buffer empty.
- Byte accepted on tx_valid_i & tx_ready_o.
- Buffer cleared on the WRITE_THR ack cycle.
REQ-013 SHALL hold a one-entry RX buffer:
- On the READ_RBR ack, rx_data_o <= wbm_dat_i and rx_valid_o <= 1.
- rx_valid_o cleared on rx_valid_o & rx_ready_i.
- rx_data_o stable while rx_valid_o=1.
REQ-014 SHALL accept a TX byte in the same cycle a WRITE_THR ack clears the buffer only from the following cycle (no same-cycle refill).
REQ-015 SHALL count cycles with stb asserted; at ACK_TIMEOUT cycles without ack it SHALL:
- Drop cyc/stb.
- Pulse err_o for one cycle.
- Abandon the access (TX buffer retained, RX unchanged).
- Resume: the current init step retries; post-init returns to POLL_LSR.
REQ-016 SHALL keep the timeout counter saturating, 8 bits wide, cleared at each access start.
REQ-017 SHALL not issue any access with LSR state older than the most recent POLL_LSR read.

Reset
REQ-018 On wb_rst_i=1 at a clock edge, SHALL set the following, aborting any bus cycle in progress:
- State INIT_LCR_DLAB.
- wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0.
- tx_ready_o=0, rx_valid_o=0, rx_data_o=0, init_done_o=0, err_o=0.
- Buffers empty, timeout counter 0.
REQ-019 SHALL start the first init access no earlier than the first cycle after wb_rst_i deasserts.

Verification
REQ-020 Reset release, slave acks in 1 cycle -> writes observed in order (3:83, 0:1B, 1:00, 3:03, 2:07, 1:00); init_done_o=1 after the sixth ack.
REQ-021 Host sends 8'hA5 and LSR returns 8'h20 -> exactly one write adr 0 data A5; tx_ready_o returns to 1 the cycle after the ack.
REQ-022 LSR returns 8'h21, TX byte pending, RX buffer empty -> READ_RBR precedes WRITE_THR; RBR value 8'h3C appears on rx_data_o with rx_valid_o=1.
REQ-023 rx_ready_i held 0 with LSR[0]=1 -> no further adr 0 reads; polling continues; rx_data_o unchanged until the handshake.
REQ-024 Slave never acks a WRITE_THR -> cyc/stb drop after 255 cycles; err_o pulses once; byte is rewritten after the next poll with ack enabled.
REQ-025 wb_rst_i asserted mid-access (stb high) -> cyc/stb 0 the next cycle; init restarts from 3:83.
